// File: rtl/alu_arbiter_ctrl.sv
// alu_arbiter_ctrl: two-requester arbiter in front of a small 8-opcode ALU.
// A request is accepted in IDLE, computed in EXEC and presented in DONE
// until the consumer takes it with rsp_ready.
// Build option: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// when it is left undefined, requester 0 has fixed priority.
module alu_arbiter_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_INV = 3'b110;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic             rspValid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;

  logic             anyReq;
  logic             winner_d;
  logic [WIDTH-1:0] result_d;
  logic             carry_d;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Priority pointer: the requester that wins the next tie.
  logic ptr_q;

  // On a tie the pointer decides; otherwise whoever is requesting wins.
  always_comb begin
    winner_d = 1'b0;
    if (req0 && req1) begin
      winner_d = ptr_q;
    end else if (req1) begin
      winner_d = 1'b1;
    end
  end

  // The pointer moves to the other requester only when a grant is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (state_q == IDLE && anyReq) begin
      ptr_q <= ~winner_d;
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it is requesting.
  always_comb begin
    winner_d = 1'b0;
    if (!req0 && req1) begin
      winner_d = 1'b1;
    end
  end
`endif

  assign anyReq = req0 | req1;

  // The grant marks the very cycle in which the operands are sampled, so it
  // is decoded from the IDLE state rather than registered a cycle late.
  assign gnt0 = (state_q == IDLE) && anyReq && !winner_d;
  assign gnt1 = (state_q == IDLE) && anyReq &&  winner_d;

  // ALU on the captured operands; carry is carry-out or borrow.
  always_comb begin
    logic [WIDTH:0] ext;
    ext      = '0;
    result_d = '0;
    carry_d  = 1'b0;
    case (op_q)
      OP_ADD: begin
        ext      = {1'b0, a_q} + {1'b0, b_q};
        result_d = ext[WIDTH-1:0];
        carry_d  = ext[WIDTH];
      end
      OP_SUB: begin
        result_d = a_q - b_q;
        carry_d  = (a_q < b_q);
      end
      OP_INC: begin
        ext      = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
        result_d = ext[WIDTH-1:0];
        carry_d  = ext[WIDTH];
      end
      OP_DEC: begin
        result_d = a_q - {{(WIDTH-1){1'b0}}, 1'b1};
        carry_d  = (a_q == '0);
      end
      OP_AND:  result_d = a_q & b_q;
      OP_OR:   result_d = a_q | b_q;
      OP_INV:  result_d = ~a_q;
      default: result_d = a_q;
    endcase
  end

  // Main controller: capture in IDLE, compute in EXEC, hold in DONE until
  // rsp_ready; response registers keep their value outside DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rspValid_q <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            op_q    <= winner_d ? op1 : op0;
            a_q     <= winner_d ? a1  : a0;
            b_q     <= winner_d ? b1  : b0;
            id_q    <= winner_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q   <= result_d;
          carry_q    <= carry_d;
          zero_q     <= (result_d == '0);
          rspValid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          rspValid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // The response id is captured together with the result so that it
  // changes only when a new result is produced.
  logic rspId_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspId_q <= 1'b0;
    end else if (state_q == EXEC) begin
      rspId_q <= id_q;
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// tb_alu_arbiter_ctrl: directed vector table for single-requester
// transactions, plus hand-written sequences for back-pressure, reset
// during EXEC and simultaneous-request arbitration.
// Honours ALU_ARB_ROUND_ROBIN_EN to pick the expected grant order.
module tb_alu_arbiter_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [2:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] result;
  logic       carry;
  logic       zero;

  int compared;
  int mismatched;

  typedef struct {
    string      name;
    logic       useReq1;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expResult;
    logic       expCarry;
    logic       expZero;
  } vec_t;

  vec_t vecs[11];

  alu_arbiter_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .op0       (op0),
    .op1       (op1),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .result    (result),
    .carry     (carry),
    .zero      (zero)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one request and wait (bounded) for its grant; returns which
  // requester was granted, or -1 if no grant arrived.
  task automatic waitGrant(output int who);
    who = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt0 && gnt1) begin
        checkOutput("gnt_onehot", {gnt1, gnt0}, 2'b01);
        who = 0;
        break;
      end
      if (gnt0) begin who = 0; break; end
      if (gnt1) begin who = 1; break; end
    end
  endtask

  // Drive one single-requester vector and check grant, latency and response.
  task automatic applyStimulus(input vec_t v);
    int who;
    int lat;
    @(posedge clk); #1;
    if (v.useReq1) begin
      req1 = 1'b1; op1 = v.op; a1 = v.a; b1 = v.b;
    end else begin
      req0 = 1'b1; op0 = v.op; a0 = v.a; b0 = v.b;
    end
    waitGrant(who);
    checkOutput({v.name, "_gnt"}, who, v.useReq1 ? 1 : 0);
    lat = 0;
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (gnt0 || gnt1) checkOutput({v.name, "_gnt_busy"}, {gnt1, gnt0}, 2'b00);
      if (rsp_valid) break;
      if (i > 0) @(posedge clk);
    end
    checkOutput({v.name, "_latency"}, lat, 2);
    checkOutput({v.name, "_result"}, result, v.expResult);
    checkOutput({v.name, "_carry"}, carry, v.expCarry);
    checkOutput({v.name, "_zero"}, zero, v.expZero);
    checkOutput({v.name, "_id"}, rsp_id, v.useReq1);
    @(negedge clk);
    checkOutput({v.name, "_valid_drop"}, rsp_valid, 1'b0);
    checkOutput({v.name, "_hold"}, result, v.expResult);
  endtask

  initial begin
    int who;
    int grants[4];
    int expGrants[4];
    logic sawValid;
    compared   = 0;
    mismatched = 0;

    vecs[0]  = '{"add_f0_20", 1'b0, 3'b000, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
    vecs[1]  = '{"dec_00",    1'b1, 3'b011, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0};
    vecs[2]  = '{"sub_55_55", 1'b1, 3'b001, 8'h55, 8'h55, 8'h00, 1'b0, 1'b1};
    vecs[3]  = '{"sw_add",    1'b0, 3'b000, 8'hA5, 8'h3C, 8'hE1, 1'b0, 1'b0};
    vecs[4]  = '{"sw_sub",    1'b1, 3'b001, 8'hA5, 8'h3C, 8'h69, 1'b0, 1'b0};
    vecs[5]  = '{"sw_inc",    1'b0, 3'b010, 8'hA5, 8'h3C, 8'hA6, 1'b0, 1'b0};
    vecs[6]  = '{"sw_dec",    1'b1, 3'b011, 8'hA5, 8'h3C, 8'hA4, 1'b0, 1'b0};
    vecs[7]  = '{"sw_and",    1'b0, 3'b100, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0};
    vecs[8]  = '{"sw_or",     1'b1, 3'b101, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0};
    vecs[9]  = '{"sw_inv",    1'b0, 3'b110, 8'hA5, 8'h3C, 8'h5A, 1'b0, 1'b0};
    vecs[10] = '{"sw_id",     1'b1, 3'b111, 8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b0};

    rst_n = 1'b0; rsp_ready = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_outputs", {gnt0, gnt1, rsp_valid, rsp_id, carry, zero, result}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    // Back-pressure: response must hold while rsp_ready stays low.
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b1; op0 = 3'b000; a0 = 8'hF0; b0 = 8'h20;
    waitGrant(who);
    checkOutput("bp_gnt", who, 0);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", rsp_valid, 1'b1);
      checkOutput("bp_result", result, 8'h10);
      checkOutput("bp_gnt_low", {gnt1, gnt0}, 2'b00);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release", rsp_valid, 1'b0);

    // Reset in the middle of EXEC aborts the operation.
    @(posedge clk); #1;
    req0 = 1'b1; op0 = 3'b000; a0 = 8'h12; b0 = 8'h34;
    waitGrant(who);
    checkOutput("rx_gnt", who, 0);
    @(posedge clk); #1;
    req0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rx_async_clear", {gnt0, gnt1, rsp_valid, rsp_id, carry, zero, result}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) sawValid = 1'b1;
    end
    checkOutput("rx_no_response", sawValid, 1'b0);

    // Both requesters held high: grant order depends on the build.
`ifdef ALU_ARB_ROUND_ROBIN_EN
    expGrants = '{0, 1, 0, 1};
`else
    expGrants = '{0, 0, 0, 0};
`endif
    @(posedge clk); #1;
    req0 = 1'b1; op0 = 3'b010; a0 = 8'h01; b0 = 8'h00;
    req1 = 1'b1; op1 = 3'b011; a1 = 8'h01; b1 = 8'h00;
    for (int k = 0; k < 4; k++) begin
      waitGrant(who);
      grants[k] = who;
      @(posedge clk);
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("arb_grant%0d", k), grants[k], expGrants[k]);
    end
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_arbiter_ctrl.md
ALU_ARBITER_CTRL -- requirements
Module: alu_arbiter_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: req0, req1  input  1  each requester's valid request.
REQ-005 SHALL have ports: op0, op1  input  3  opcodes, encoded 000 add, 001 sub, 010 inc, 011 dec, 100 and, 101 or, 110 inv, 111 identity.
REQ-006 SHALL have ports: a0, b0, a1, b1  input  WIDTH  operands per requester.
REQ-007 SHALL have ports: gnt0, gnt1  output  1  one-cycle accept pulse per requester.
REQ-008 SHALL have ports: rsp_valid  output  1  result available; rsp_ready  input  1  consumer accepts result.
REQ-009 SHALL have ports: rsp_id  output  1  winning requester; result  output  WIDTH; carry  output  1; zero  output  1.

Function
REQ-010 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE, one state per cycle except DONE.
REQ-011 In IDLE with req0 or req1 high, SHALL select one winner, register its op/a/b, pulse the matching gnt for exactly that cycle, and go to EXEC.
REQ-012 In IDLE with no request, SHALL stay in IDLE with gnt0=gnt1=0.
REQ-013 gnt0 and gnt1 SHALL never be high in the same cycle; gnt SHALL be low in EXEC and DONE.
REQ-014 Requests SHALL be sampled only in IDLE; requester must hold req and operands until its gnt.
REQ-015 In EXEC, SHALL compute on registered operands and register result, carry, zero, rsp_id; go to DONE.
REQ-016 Arithmetic SHALL be modulo 2^WIDTH: add a+b, sub a-b, inc a+1, dec a-1; b ignored for inc/dec/inv/identity.
REQ-017 carry SHALL be carry-out of add/inc, borrow (a<b for sub, a==0 for dec) for sub/dec, and 0 for logic ops.
REQ-018 zero SHALL be 1 iff registered result equals 0.
REQ-019 In DONE, rsp_valid SHALL be 1 and result/carry/zero/rsp_id SHALL be stable until rsp_ready is sampled high; then go to IDLE.
REQ-020 Latency gnt-to-rsp_valid SHALL be 2 cycles; minimum request-to-request spacing 3 cycles.
REQ-021 rsp_ready while rsp_valid=0 SHALL be ignored.
REQ-022 Outputs result, carry, zero, rsp_id SHALL hold their last value outside DONE.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, gnt0=gnt1=0, rsp_valid=0, result=0, carry=0, zero=0, rsp_id=0, round-robin pointer to requester 0.
REQ-024 Reset asserted mid-EXEC or mid-DONE SHALL abort the operation; no response for it SHALL appear after reset release.
REQ-025 First arbitration SHALL occur on the first rising edge with rst_n high.

Configuration
REQ-026 Macro ALU_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-027 With ALU_ARB_ROUND_ROBIN_EN defined: on simultaneous req0 and req1, winner SHALL be the requester not granted last; pointer updates only on a grant.
REQ-028 Without ALU_ARB_ROUND_ROBIN_EN: requester 0 SHALL always win on simultaneous requests (fixed priority); no pointer state exists.

Verification
REQ-029 WIDTH=8, req0 only, op0=000, a0=8'hF0, b0=8'h20 -> gnt0 pulse, 2 cycles later rsp_valid, result=8'h10, carry=1, zero=0, rsp_id=0.
REQ-030 req1 only, op1=011, a1=8'h00 -> result=8'hFF, carry=1; op1=001, a1=b1=8'h55 -> result=0, zero=1, carry=0.
REQ-031 req0 and req1 held high continuously, rsp_ready=1 -> RR build grants 0,1,0,1; fixed-priority build grants 0,0,0,0.
REQ-032 rsp_ready held 0 for 5 cycles in DONE -> rsp_valid and result stable 5 cycles, no gnt; rsp_ready=1 -> IDLE next cycle.
REQ-033 rst_n pulsed low during EXEC of an add -> all outputs 0 immediately, no rsp_valid until a new request.
REQ-034 Sweep all 8 opcodes with a=8'hA5, b=8'h3C -> results 8'hE1, 8'h69, 8'hA6, 8'hA4, 8'h24, 8'hBD, 8'h5A, 8'hA5.
